// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and FSM state type for the audio frame packer
package audio_pkg;
  localparam int SAMPLE_W = 24;
  localparam logic CHAN_LEFT = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;
  typedef enum logic [1:0] {WAIT_L, WAIT_R, PUSH} packer_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: pairs left/right samples into 48-bit stereo frames for the I2S FIFO
module audio_frame_packer #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mute,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_chan,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [2*SAMPLE_W-1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_almost_full,
  input  logic                  fifo_full,
  input  logic                  clear_counts,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      sync_err_count
);
  import audio_pkg::*;
  packer_state_t state_q, state_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [2*SAMPLE_W-1:0] din_q, din_d;
  logic accept, err_inc;
  // almost_full only blocks the start of a new frame; a held left sample always gets its right
  assign s_ready = !reset && enable && (state_q == WAIT_R || (state_q == WAIT_L && !fifo_almost_full));
  assign accept = s_valid && s_ready;
  assign fifo_wr_en = !reset && state_q == PUSH && !fifo_full;
  assign fifo_din = din_q;
  always_comb begin
    state_d = state_q;
    left_d = left_q;
    din_d = din_q;
    err_inc = 1'b0;
    case (state_q)
      WAIT_L: if (accept) begin
        if (s_chan == CHAN_LEFT) begin
          left_d = s_data;
          state_d = WAIT_R;
        end else err_inc = 1'b1;
      end
      WAIT_R: if (!enable) state_d = WAIT_L;
      else if (accept) begin
        if (s_chan == CHAN_RIGHT) begin
          din_d = mute ? '0 : {left_q, s_data};
          state_d = PUSH;
        end else begin
          left_d = s_data;
          err_inc = 1'b1;
        end
      end
      default: if (fifo_wr_en) state_d = WAIT_L;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_L;
      left_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      left_q <= left_d;
      din_q <= din_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk(clk), .reset(reset), .clr(clear_counts), .inc(fifo_wr_en), .count(frame_count)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .clr(clear_counts), .inc(err_inc), .count(sync_err_count)
  );
endmodule
